// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage -- PC, imem req/gnt/rvalid handshake, one-entry IF slot, IF/DEC register.
// Build option FETCH_MISALIGN_CHECK_EN: a misaligned branch target sets a sticky trap that halts fetch.
//
// state   | meaning
// S_IDLE  | no fetch outstanding
// S_WAIT  | one granted fetch awaiting imem_rvalid
// S_FLUSH | outstanding response belongs to a squashed path and is discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  fetch_sel,
    input  logic [31:0] branch_target,
    input  logic        nop_output_fetch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [6:0]  opcode_fetch,
    output logic [31:0] instr_dec,
    output logic [31:0] pc_dec,
    output logic        valid_dec,
    output logic        fetch_misaligned
);
    localparam logic [31:0] BUBBLE     = 32'h0000_0013;
    localparam logic [6:0]  OP_BUBBLE  = 7'b0010011;
    localparam logic [1:0]  SEL_PC     = 2'd0;
    localparam logic [1:0]  SEL_BRANCH = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] instr_dec_q, instr_dec_d;
    logic [31:0] pc_dec_q, pc_dec_d;
    logic        valid_dec_q, valid_dec_d;
    logic        mis_q, mis_d;

    logic        sel_pc, sel_branch, sel_nop;
    logic        dec_take, slot_free, resp, accept, fire;
    logic [31:0] target;
    logic        target_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target     = branch_target;
    assign target_bad = |branch_target[1:0];
`else
    logic unused_target_lsb;
    assign unused_target_lsb = ^branch_target[1:0];
    assign target            = {branch_target[31:2], 2'b00};
    assign target_bad        = 1'b0;
`endif

    assign sel_pc     = (fetch_sel == SEL_PC);
    assign sel_branch = (fetch_sel == SEL_BRANCH);
    assign sel_nop    = fetch_sel[1];

    // DEC consumes the slot (or a bubble) on advance and on a flushing stall.
    assign dec_take  = sel_pc | (sel_nop & nop_output_fetch);
    assign slot_free = ~if_valid_q | dec_take;
    assign resp      = imem_rvalid & (state_q == S_WAIT);
    assign accept    = resp & ~sel_branch & slot_free;

    assign imem_req  = rst_n & sel_pc & ~mis_q & slot_free &
                       ((state_q == S_IDLE) | resp);
    assign fire      = imem_req & imem_gnt;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        instr_dec_d = instr_dec_q;
        pc_dec_d    = pc_dec_q;
        valid_dec_d = valid_dec_q;
        mis_d       = mis_q | (sel_branch & target_bad);

        case (state_q)
            S_IDLE: begin
                if (fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sel_branch)  state_d = imem_rvalid ? S_IDLE : S_FLUSH;
                else if (accept) state_d = fire ? S_WAIT : S_IDLE;
            end
            S_FLUSH: begin
                if (imem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sel_branch) begin
            pc_d = target;
        end else if (fire) begin
            pc_d       = pc_q + 32'd4;
            fetch_pc_d = pc_q;
        end

        if (sel_branch) begin
            if_valid_d  = 1'b0;
            instr_dec_d = BUBBLE;
            pc_dec_d    = '0;
            valid_dec_d = 1'b0;
        end else begin
            if (dec_take) begin
                if (if_valid_q && !mis_q) begin
                    instr_dec_d = if_instr_q;
                    pc_dec_d    = if_pc_q;
                    valid_dec_d = 1'b1;
                end else begin
                    instr_dec_d = BUBBLE;
                    pc_dec_d    = '0;
                    valid_dec_d = 1'b0;
                end
                if_valid_d = 1'b0;
            end
            if (accept) begin
                if_instr_d = imem_rdata;
                if_pc_d    = fetch_pc_q;
                if_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            if_instr_q  <= BUBBLE;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
            instr_dec_q <= BUBBLE;
            pc_dec_q    <= '0;
            valid_dec_q <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            instr_dec_q <= instr_dec_d;
            pc_dec_q    <= pc_dec_d;
            valid_dec_q <= valid_dec_d;
            mis_q       <= mis_d;
        end
    end

    assign imem_addr        = pc_q;
    assign opcode_fetch     = if_valid_q ? if_instr_q[6:0] : OP_BUBBLE;
    assign instr_dec        = instr_dec_q;
    assign pc_dec           = pc_dec_q;
    assign valid_dec        = valid_dec_q;
    assign fetch_misaligned = mis_q;

endmodule
